// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - four-digit active-low seven-segment scan controller
// Shadow-buffered result codes are applied only at frame boundaries; dead time blanks between digits.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int DEAD_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] codes_in,
  input  logic [3:0] blank_in,
  output logic [3:0] an_out,
  output logic [7:0] seg_out,
  output logic       frame_start,
  output logic       upd_pending
);

  localparam int MAX_CYC = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
  localparam int CW      = $clog2((MAX_CYC > 2) ? MAX_CYC : 2);
  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = (DEAD_CYCLES > 0) ? CW'(DEAD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    act_codes, sh_codes, codes_nxt;
  logic [3:0]    act_blank, sh_blank, blank_nxt;
  logic          wrap, do_apply, fs_nxt;
  logic [3:0]    an_nxt;
  logic [7:0]    seg_nxt;

  function automatic logic [7:0] decode(input logic [1:0] code);
    case (code)
      2'b00:   decode = 8'b00000011;
      2'b01:   decode = 8'b00010001;
      2'b10:   decode = 8'b10000011;
      default: decode = 8'b11100011;
    endcase
  endfunction

  // Next-state: wrap marks entry into digit 0, which is where shadow data may be applied.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    wrap      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = 2'd0;
        if (en) begin
          state_nxt = DRIVE;
          wrap      = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == R_LAST) begin
          cnt_nxt = '0;
          if (DEAD_CYCLES == 0) begin
            idx_nxt = idx + 2'd1;
            wrap    = (idx == 2'd3);
          end else begin
            state_nxt = DEAD;
          end
        end
      end
      DEAD: begin
        if (cnt == D_LAST) begin
          cnt_nxt   = '0;
          state_nxt = DRIVE;
          idx_nxt   = idx + 2'd1;
          wrap      = (idx == 2'd3);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
      wrap      = 1'b0;
    end
  end

  assign do_apply  = wrap && upd_pending;
  assign codes_nxt = do_apply ? sh_codes : act_codes;
  assign blank_nxt = do_apply ? sh_blank : act_blank;
  assign fs_nxt    = wrap;

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 8'hFF;
    if (state_nxt == DRIVE && !blank_nxt[idx_nxt]) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = decode(codes_nxt[{idx_nxt, 1'b0} +: 2]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      act_codes   <= 8'h00;
      act_blank   <= 4'b1111;
      sh_codes    <= 8'h00;
      sh_blank    <= 4'b0000;
      upd_pending <= 1'b0;
      an_out      <= 4'b1111;
      seg_out     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      act_codes   <= codes_nxt;
      act_blank   <= blank_nxt;
      an_out      <= an_nxt;
      seg_out     <= seg_nxt;
      frame_start <= fs_nxt;
      // A load on the apply edge wins the shadow and keeps the update pending.
      if (load) begin
        sh_codes    <= codes_in;
        sh_blank    <= blank_in;
        upd_pending <= 1'b1;
      end else if (do_apply) begin
        upd_pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexes one shared 8-bit active-low segment bus across four common-anode digits, each showing a 2-bit result code (0, A, U, L).
- Sits between the result logic and the board pins.
- Latches new result codes through a shadow register and applies them only at frame boundaries, so a frame never shows a mix of old and new codes.
- Inserts a blanking dead time between digits to suppress ghosting.

Parameters:
- REFRESH_CYCLES, 100000: clock cycles each digit is driven; legal range ≥1.
- DEAD_CYCLES, 1000: all-off cycles after each digit; 0 means no dead phase.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  1 = scan active; 0 = display off.
- load  input  1  single-cycle strobe; captures codes_in and blank_in into the shadow register.
- codes_in  input  8  digit i code at bits [2i+1:2i].
- blank_in  input  4  bit i = 1 blanks digit i.
- an_out  output  4  active-low digit enables; bit i = digit i.
- seg_out  output  8  active-low segments {a,b,c,d,e,f,g,dp}.
- frame_start  output  1  one-cycle pulse on the first drive cycle of digit 0.
- upd_pending  output  1  shadow holds data not yet applied.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- All outputs are registered and reflect the current FSM state in the same cycle.
- Reset values:
  - an_out = 4'b1111, seg_out = 8'hFF, frame_start = 0, upd_pending = 0.
  - FSM = IDLE, digit index = 0, counter = 0.
  - Active codes = 0, active blank = 4'b1111, shadow cleared.
- Code decode (no dp):
  - 00 → 8'b00000011 (0)
  - 01 → 8'b00010001 (A)
  - 10 → 8'b10000011 (U)
  - 11 → 8'b11100011 (L)
- IDLE state:
  - an_out = 1111, seg_out = FF.
  - When en = 1, the next cycle enters DRIVE, digit 0, counter 0, with frame_start = 1.
  - If upd_pending = 1 on that entry, the shadow is copied to active and upd_pending clears.
- DRIVE state:
  - an_out has a 0 only at the current digit; seg_out = decode(active code[idx]).
  - If active blank[idx] = 1: an_out = 1111 and seg_out = FF, but the timing is unchanged.
  - Counter increments each cycle. At REFRESH_CYCLES−1 the FSM goes to DEAD (or directly to the next digit if DEAD_CYCLES = 0) and the counter resets to 0.
- DEAD state:
  - an_out = 1111, seg_out = FF.
  - At DEAD_CYCLES−1 the FSM goes to DRIVE with idx+1.
  - From idx 3 it wraps to 0. This is the frame boundary: apply the shadow if pending, and frame_start = 1 on the first DRIVE cycle of digit 0.
- Frame length = 4·(REFRESH_CYCLES + DEAD_CYCLES) cycles.
- load:
  - Accepted in any state, including IDLE and with en = 0.
  - Shadow ← {codes_in, blank_in}; upd_pending = 1 from the next cycle.
  - Back-to-back loads: last one wins.
- load coinciding with an apply edge:
  - The apply uses the pre-load shadow.
  - The new data is captured and upd_pending stays 1, so it applies at the next boundary.
- en = 0 in any state: the next cycle is IDLE with outputs off; counters and index reset to 0. Active codes and the shadow are retained.
- rst mid-operation: all state returns to reset values on that edge; a pending update is discarded.
- Counter width = clog2(max(REFRESH_CYCLES, DEAD_CYCLES, 2)). No overflow is possible.

Test Plan:
All scenarios use REFRESH_CYCLES = 4 and DEAD_CYCLES = 1 (frame = 20 cycles).
1. Reset and idle: rst = 1 for 2 cycles with en = 0 → an_out = 1111, seg_out = FF, upd_pending = 0, frame_start = 0, held indefinitely.
2. Normal scan: load codes_in = 8'b11100100 with blank_in = 0000, then en = 1 →
   - digit 0: an 1110, seg 00000011, 4 cycles; then 1 cycle of 1111/FF.
   - digit 1: an 1101, seg 00010001.
   - digit 2: an 1011, seg 10000011.
   - digit 3: an 0111, seg 11100011.
   - frame_start pulses every 20 cycles.
3. Tear-free update: during digit 1, load codes_in = 8'h00 →
   - digits 2 and 3 still show U and L; upd_pending = 1 until wrap.
   - The next digit 0 shows 00000011, digit 3 shows 00000011, and upd_pending clears in that cycle.
4. Simultaneous load and boundary: load 8'h55 in the first cycle of the frame_start DRIVE cycle, after a prior load of 8'hFF is pending → that frame shows L on all digits; upd_pending stays 1; the next frame shows A on all digits.
5. Blanking: blank_in = 0101 →
   - digits 0 and 2 slots: an 1111 / seg FF for 4 cycles each.
   - digits 1 and 3 drive normally; frame is still 20 cycles.
6. en drop and reset:
   - en = 0 mid-digit 2 → next cycle an 1111 / seg FF; re-enable → starts at digit 0 with a frame_start pulse.
   - rst mid-digit 3 with a load pending → next cycle reset values, upd_pending = 0; en = 1 afterwards shows all digits blank.
